// File: rtl/mpf_vtp_lookup_responder.sv
// VTP lookup responder: a small fully-associative 4KB page table resolves
// line-granular requests in one stage and returns in-order responses via a FIFO.

module mpf_vtp_entry #(
  parameter int PW = 36
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic          inval,
  input  logic [PW-1:0] wvpn,
  input  logic [PW-1:0] wppn,
  input  logic          wvalid,
  input  logic [PW-1:0] lookup_vpn,
  output logic          hit,
  output logic [PW-1:0] ppn
);
  logic [PW-1:0] vpn;
  logic          valid;

  // A fill on the same edge as inval_all wins for its own entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   valid <= 1'b0;
    else if (we)    valid <= wvalid;
    else if (inval) valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      vpn <= wvpn;
      ppn <= wppn;
    end
  end

  assign hit = valid && (vpn == lookup_vpn);
endmodule

module mpf_vtp_lookup_responder #(
  parameter int N_ENTRIES       = 8,
  parameter int LINE_ADDR_WIDTH = 42,
  parameter int N_TAG_BITS      = 8,
  parameter int RSP_FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [LINE_ADDR_WIDTH-1:0]   req_addr,
  input  logic                         req_is_virtual,
  input  logic                         req_is_speculative,
  input  logic [N_TAG_BITS-1:0]        req_tag,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [LINE_ADDR_WIDTH-1:0]   rsp_addr,
  output logic                         rsp_error,
  output logic [N_TAG_BITS-1:0]        rsp_tag,
  input  logic                         fill_en,
  input  logic [$clog2(N_ENTRIES)-1:0] fill_idx,
  input  logic [LINE_ADDR_WIDTH-7:0]   fill_vpn,
  input  logic [LINE_ADDR_WIDTH-7:0]   fill_ppn,
  input  logic                         fill_valid,
  input  logic                         inval_all,
  output logic                         fatal_miss,
  output logic [31:0]                  hit_cnt,
  output logic [31:0]                  miss_cnt
);
  localparam int W  = LINE_ADDR_WIDTH;
  localparam int PW = W - 6;
  localparam int IW = $clog2(N_ENTRIES);
  localparam int FW = $clog2(RSP_FIFO_DEPTH);
  localparam int CW = FW + 1;

  typedef struct packed {
    logic [W-1:0]          addr;
    logic                  error;
    logic [N_TAG_BITS-1:0] tag;
  } rsp_t;

  // Stage 1
  logic                  s1_valid, s1_virt, s1_spec;
  logic [W-1:0]          s1_addr;
  logic [N_TAG_BITS-1:0] s1_tag;

  logic [N_ENTRIES-1:0]         ent_hit;
  logic [N_ENTRIES-1:0][PW-1:0] ent_ppn;

  for (genvar i = 0; i < N_ENTRIES; i++) begin : g_ent
    mpf_vtp_entry #(.PW(PW)) u_ent (
      .clk        (clk),
      .reset_n    (reset_n),
      .we         (fill_en && (fill_idx == IW'(i))),
      .inval      (inval_all),
      .wvpn       (fill_vpn),
      .wppn       (fill_ppn),
      .wvalid     (fill_valid),
      .lookup_vpn (s1_addr[W-1:6]),
      .hit        (ent_hit[i]),
      .ppn        (ent_ppn[i])
    );
  end

  // Lowest index wins on multiple hits: scan high to low, last match sticks.
  logic          hit_any;
  logic [PW-1:0] sel_ppn;
  always_comb begin
    hit_any = 1'b0;
    sel_ppn = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (ent_hit[i]) begin
        hit_any = 1'b1;
        sel_ppn = ent_ppn[i];
      end
    end
  end

  rsp_t s1_rsp;
  always_comb begin
    s1_rsp.addr  = s1_addr;
    s1_rsp.error = 1'b0;
    s1_rsp.tag   = s1_tag;
    if (s1_virt) begin
      if (hit_any) s1_rsp.addr  = {sel_ppn, s1_addr[5:0]};
      else         s1_rsp.error = 1'b1;
    end
  end

  // Response FIFO
  rsp_t          fifo_mem [RSP_FIFO_DEPTH];
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          push, pop;

  assign push      = s1_valid;
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_addr  = fifo_mem[rd_ptr].addr;
  assign rsp_error = fifo_mem[rd_ptr].error;
  assign rsp_tag   = fifo_mem[rd_ptr].tag;

  // Counts the stage-1 slot so a push always fits; pops don't free same-cycle space.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, s1_valid};
  assign req_ready = occ < (CW+1)'(RSP_FIFO_DEPTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_virt  <= 1'b0;
      s1_spec  <= 1'b0;
      s1_addr  <= '0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= req_valid && req_ready;
      if (req_valid && req_ready) begin
        s1_virt <= req_is_virtual;
        s1_spec <= req_is_speculative;
        s1_addr <= req_addr;
        s1_tag  <= req_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= s1_rsp;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      fatal_miss <= 1'b0;
    end else if (s1_valid && s1_virt) begin
      if (hit_any) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
        if (!s1_spec) fatal_miss <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mpf_vtp_lookup_responder.sv
// Scoreboard bench for mpf_vtp_lookup_responder: directed requests push expected
// responses; a negedge monitor pops and compares on every handshake.

module tb_mpf_vtp_lookup_responder;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        req_valid = 0, req_ready;
  logic [41:0] req_addr = '0;
  logic        req_is_virtual = 0, req_is_speculative = 0;
  logic [7:0]  req_tag = '0;
  logic        rsp_valid, rsp_ready = 1, rsp_error;
  logic [41:0] rsp_addr;
  logic [7:0]  rsp_tag;
  logic        fill_en = 0, fill_valid = 0, inval_all = 0;
  logic [2:0]  fill_idx = '0;
  logic [35:0] fill_vpn = '0, fill_ppn = '0;
  logic        fatal_miss;
  logic [31:0] hit_cnt, miss_cnt;

  mpf_vtp_lookup_responder dut (
    .clk(clk), .reset_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_is_virtual(req_is_virtual), .req_is_speculative(req_is_speculative), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_error(rsp_error), .rsp_tag(rsp_tag),
    .fill_en(fill_en), .fill_idx(fill_idx), .fill_vpn(fill_vpn), .fill_ppn(fill_ppn),
    .fill_valid(fill_valid), .inval_all(inval_all),
    .fatal_miss(fatal_miss), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [41:0] addr;
    logic        err;
    logic [7:0]  tag;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0, n_fail = 0;

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: got addr=%h err=%0d tag=%h, no response expected",
                 rsp_addr, rsp_error, rsp_tag);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        if (rsp_addr !== e.addr || rsp_error !== e.err || rsp_tag !== e.tag) begin
          n_fail++;
          $display("FAIL rsp_tag%h: got addr=%h err=%0d tag=%h, want addr=%h err=%0d tag=%h",
                   e.tag, rsp_addr, rsp_error, rsp_tag, e.addr, e.err, e.tag);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [41:0] a, input logic virt, input logic spec,
                      input logic [7:0] tag, input logic [41:0] ea, input logic ee);
    int t = 0;
    req_valid = 1; req_addr = a; req_is_virtual = virt;
    req_is_speculative = spec; req_tag = tag;
    @(negedge clk);
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (!req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL req_accept: req_ready stuck at 0, want 1");
    end else begin
      exp_q.push_back('{ea, ee, tag});
    end
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic fill(input logic [2:0] idx, input logic [35:0] v, input logic [35:0] p,
                      input logic fv, input logic inv);
    fill_en = 1; fill_idx = idx; fill_vpn = v; fill_ppn = p; fill_valid = fv; inval_all = inv;
    @(posedge clk); #1;
    fill_en = 0; inval_all = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] pg;
    logic [41:0] a, ea;
    logic [41:0] held_addr;
    logic [7:0]  held_tag;
    int acc, sent_tag, cyc;

    #12 rst_n = 1;
    @(posedge clk); #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    check("rst_fatal", fatal_miss, 0);

    // basic hit with latency check
    fill(0, 36'h12345, 36'hABCDE, 1, 0);
    pg = 36'h12345; a = {pg, 6'h2A};
    pg = 36'hABCDE; ea = {pg, 6'h2A};
    send(a, 1, 0, 8'h05, ea, 0);
    @(negedge clk); check("lat_edge1_valid", rsp_valid, 0);
    @(negedge clk); check("lat_edge2_valid", rsp_valid, 1);
    drain();
    check("hit_cnt_1", hit_cnt, 1);

    // non-speculative miss, then speculative miss
    pg = 36'h777; a = {pg, 6'h01};
    send(a, 1, 0, 8'h06, a, 1);
    drain();
    check("miss_cnt_1", miss_cnt, 1);
    check("fatal_set", fatal_miss, 1);
    send(a, 1, 1, 8'h07, a, 1);
    drain();
    check("miss_cnt_2", miss_cnt, 2);
    check("fatal_sticky", fatal_miss, 1);

    // pass-through
    send(42'h3FF, 0, 0, 8'h08, 42'h3FF, 0);
    drain();
    check("nv_hit_cnt", hit_cnt, 1);
    check("nv_miss_cnt", miss_cnt, 2);

    // duplicate vpn at idx 3: idx 0 must win
    fill(3, 36'h12345, 36'h55555, 1, 0);
    pg = 36'h12345; a = {pg, 6'h11};
    pg = 36'hABCDE; ea = {pg, 6'h11};
    send(a, 1, 0, 8'h09, ea, 0);
    drain();
    check("hit_cnt_2", hit_cnt, 2);

    // backpressure: 6 requests against a stalled consumer
    rsp_ready = 0;
    acc = 0; sent_tag = 0; cyc = 0;
    pg = 36'h12345; req_addr = {pg, 6'h00};
    req_is_virtual = 1; req_is_speculative = 0; req_tag = 8'h10; req_valid = 1;
    while (acc < 6 && cyc < 60) begin
      @(negedge clk);
      if (cyc == 8) begin
        check("stall_accepted", acc, 4);
        check("stall_req_ready", req_ready, 0);
        held_addr = rsp_addr; held_tag = rsp_tag;
      end
      if (cyc == 11) begin
        check("stall_addr_stable", rsp_addr, held_addr);
        check("stall_tag_stable", rsp_tag, held_tag);
      end
      if (req_valid && req_ready) begin
        pg = 36'hABCDE; ea = {pg, 6'(acc)};
        exp_q.push_back('{ea, 1'b0, 8'(8'h10 + acc)});
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc == 12) rsp_ready = 1;
      pg = 36'h12345; req_addr = {pg, 6'(acc)};
      req_tag = 8'(8'h10 + acc);
      req_valid = (acc < 6);
    end
    req_valid = 0;
    rsp_ready = 1;
    drain();
    check("stall_hit_cnt", hit_cnt, 8);

    // fill lands while the lookup sits in stage 1: that lookup misses
    pg = 36'h222; a = {pg, 6'h03};
    send(a, 1, 1, 8'h20, a, 1);
    fill(1, 36'h222, 36'h333, 1, 0);
    pg = 36'h333; ea = {pg, 6'h03};
    send(a, 1, 1, 8'h21, ea, 0);
    drain();
    check("fill_s1_miss_cnt", miss_cnt, 3);
    check("fill_s1_hit_cnt", hit_cnt, 9);

    // inval_all together with a fill: only the filled entry survives
    fill(2, 36'h999, 36'h111, 1, 1);
    pg = 36'h999; a = {pg, 6'h3F};
    pg = 36'h111; ea = {pg, 6'h3F};
    send(a, 1, 1, 8'h22, ea, 0);
    pg = 36'h12345; a = {pg, 6'h04};
    send(a, 1, 1, 8'h23, a, 1);
    pg = 36'h222; a = {pg, 6'h05};
    send(a, 1, 1, 8'h24, a, 1);
    drain();
    check("inval_hit_cnt", hit_cnt, 10);
    check("inval_miss_cnt", miss_cnt, 5);

    // async reset with responses pending
    rsp_ready = 0;
    send(42'h1, 0, 0, 8'h30, 42'h1, 0);
    send(42'h2, 0, 0, 8'h31, 42'h2, 0);
    send(42'h3, 0, 0, 8'h32, 42'h3, 0);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_hit_cnt", hit_cnt, 0);
    check("arst_miss_cnt", miss_cnt, 0);
    check("arst_fatal", fatal_miss, 0);
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1;
    rsp_ready = 1;
    @(posedge clk); #1;
    check("post_rst_req_ready", req_ready, 1);
    pg = 36'h12345; a = {pg, 6'h07};
    send(a, 1, 1, 8'h40, a, 1);
    send(42'h55, 0, 0, 8'h41, 42'h55, 0);
    drain();
    check("post_rst_miss_cnt", miss_cnt, 1);
    check("post_rst_hit_cnt", hit_cnt, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mpf_vtp_lookup_responder.md
# mpf_vtp_lookup_responder

Responder side of the VTP port lookup protocol: accepts line-granular translation requests from a translate channel, resolves them against a small fully-associative table of 4KB page mappings, and returns in-order responses carrying the translated line address and an error flag. It sits behind the `mpf_vtp_translate_*` shims, where a full page-walking TLB is unnecessary: static-mapping AFUs, simulation, and bring-up. Software or a control block preloads the table through a fill port.

## Interface
- N_ENTRIES, 8: table entries, power of two, 2..64
- LINE_ADDR_WIDTH, 42: request/response line-address width (byte address >> 6)
- N_TAG_BITS, 8: opaque tag returned unchanged with each response
- RSP_FIFO_DEPTH, 4: response buffer entries, power of two, >= 2

- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  lookup request valid
- req_ready  out  1  responder can accept a request
- req_addr  in  LINE_ADDR_WIDTH  line address
- req_is_virtual  in  1  translate if 1; pass through if 0
- req_is_speculative  in  1  miss is expected and tolerated
- req_tag  in  N_TAG_BITS  opaque tag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_addr  out  LINE_ADDR_WIDTH  translated, or original, line address
- rsp_error  out  1  translation miss
- rsp_tag  out  N_TAG_BITS  tag of the matching request
- fill_en  in  1  write one table entry
- fill_idx  in  $clog2(N_ENTRIES)  entry index
- fill_vpn  in  LINE_ADDR_WIDTH-6  virtual page number
- fill_ppn  in  LINE_ADDR_WIDTH-6  physical page number
- fill_valid  in  1  entry valid bit to store
- inval_all  in  1  clear every entry's valid bit
- fatal_miss  out  1  sticky: non-speculative virtual miss seen
- hit_cnt  out  32  virtual lookups that hit, saturating
- miss_cnt  out  32  virtual lookups that missed, saturating

## Operation
- Reset values: table valid bits 0, stage-1 valid 0, FIFO empty, rsp_valid 0, fatal_miss 0, hit_cnt 0, miss_cnt 0. req_ready is 1 once reset deasserts. Reset mid-burst discards all in-flight requests.
- Accept: a request is accepted when req_valid && req_ready at a rising edge. Its fields are captured into stage 1.
- Stage 1 compares the captured page number, addr[W-1:6], against every valid entry's vpn in parallel.
  - Hit: rsp_addr = {ppn, addr[5:0]}, rsp_error = 0.
  - Multiple hits: the lowest index wins.
  - Miss: rsp_addr = req_addr unchanged, rsp_error = 1.
  - req_is_virtual = 0: rsp_addr = req_addr, rsp_error = 0, and no counter changes.
- Stage-1 results are pushed into the response FIFO at the following edge. Responses are strictly in request order.
- Counters: a virtual hit increments hit_cnt; a virtual miss increments miss_cnt. Both saturate at 32'hFFFF_FFFF.
- fatal_miss is set on a virtual miss with req_is_speculative = 0 and is cleared only by reset.
- Fill: on fill_en, entry fill_idx is written at the edge. A compare in the same cycle uses the pre-write contents.
- inval_all clears all valid bits at the edge. If fill_en and inval_all are asserted together, inval_all applies and then the fill's entry is written, so the filled entry ends up valid = fill_valid.
- Flow control: req_ready = (fifo_count + stage1_valid) < RSP_FIFO_DEPTH, computed from registered state only.
  - A dequeue in the same cycle does not free a slot for that cycle's accept.
  - The FIFO can never overflow.

## Timing
- Request accepted at edge N gives rsp_valid high from cycle N+1 after edge N+1, provided the FIFO was empty. Latency is 2 edges.
- Throughput is one request per cycle while the consumer drains every cycle and the FIFO does not fill.
- rsp_* are driven from FIFO storage. They are held stable while rsp_valid && !rsp_ready.
- FIFO full with rsp_ready = 0: req_ready stays 0 until a response dequeues. req_ready is then 1 in the cycle after the dequeue edge.
- Simultaneous push and pop on a full FIFO is legal, and the count is unchanged.
- Fill or invalidate affects lookups captured into stage 1 at or after the write edge.

## Test plan
- Fill idx 0 with vpn 0x12345, ppn 0xABCDE, valid 1. Request addr {0x12345, 6'h2A}, virtual, tag 0x5 -> 2 cycles later rsp_addr = {0xABCDE, 6'h2A}, error 0, tag 0x5, hit_cnt = 1.
- Virtual, non-speculative request to an unmapped vpn 0x777 -> rsp_error 1, rsp_addr unchanged, miss_cnt = 1, fatal_miss = 1 and stays set. Repeat the request as speculative -> fatal_miss unchanged, miss_cnt = 2.
- Non-virtual request, addr 0x3FF -> rsp_addr 0x3FF, error 0, both counters unchanged.
- Hold rsp_ready = 0 and stream 6 requests -> exactly 4 accepted, then req_ready 0 and rsp_* stable. Release rsp_ready -> all responses arrive in order with tags matching, none lost or duplicated.
- Fill idx 1 in the cycle its lookup sits in stage 1 -> that lookup misses. The next lookup hits. inval_all -> subsequent lookups miss.
- Assert reset_n low asynchronously with 3 responses pending -> rsp_valid 0 immediately, counters 0. After release, a new request completes normally.
